toggle_event_decoder: RTL and testbench

Receive-side decoder for toggle-encoded event lines, where each event is signalled by one level flip of `data`, as a T flip-flop output produces. The block synchronises and optionally glitch-filters the line, then emits a one-cycle pulse per accepted flip. It counts events and measures the cycle gap between consecutive events. Gaps are buffered in a small FIFO drained over a valid/ready handshake.

---
 rtl/toggle_event_decoder.sv | 134 +++++++++++++
 tb/tb_toggle_event_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// Toggle-encoded event decoder: synchroniser, optional glitch filter (TOGGLE_DEC_FILTER_EN),
// event pulse/counter and an inter-event gap FIFO drained over valid/ready.
module toggle_event_decoder #(
    parameter int FILTER_CYCLES = 2,
    parameter int CNT_W         = 8,
    parameter int GAP_W         = 8,
    parameter int DEPTH         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data,
    output logic             data_out,
    output logic             level,
    output logic [CNT_W-1:0] evt_count,
    output logic             gap_valid,
    output logic [GAP_W-1:0] gap_data,
    input  logic             gap_ready,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    generate
        if (FILTER_CYCLES < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
            $error("toggle_event_decoder: FILTER_CYCLES must be >= 1 and DEPTH a power of 2 >= 2");
        end
    endgenerate

    logic s1, s2;
    logic accept;

`ifdef TOGGLE_DEC_FILTER_EN
    typedef enum logic {IDLE, QUAL} state_t;
    localparam int QW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    // Count value at which one more differing sample completes qualification.
    localparam logic [QW-1:0] QUAL_LAST = QW'(FILTER_CYCLES - 1);

    state_t        state, state_next;
    logic [QW-1:0] qual_cnt, qual_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            qual_cnt <= '0;
        end else begin
            state    <= state_next;
            qual_cnt <= qual_next;
        end
    end

    always_comb begin
        state_next = state;
        qual_next  = qual_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (s2 != level) begin
                    if (qual_cnt == QUAL_LAST) begin
                        accept = 1'b1;
                    end else begin
                        state_next = QUAL;
                        qual_next  = qual_cnt + 1'b1;
                    end
                end
            end
            QUAL: begin
                if (s2 == level) begin
                    state_next = IDLE;
                    qual_next  = '0;
                end else if (qual_cnt == QUAL_LAST) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                    qual_next  = '0;
                end else begin
                    qual_next = qual_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                qual_next  = '0;
            end
        endcase
    end
`else
    assign accept = (s2 != level);
`endif

    // Gap FIFO: pointers carry an extra MSB so full and empty are distinguishable.
    logic [GAP_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [GAP_W-1:0] g, gap_inc;
    logic             full, empty, push, pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && gap_ready;
    assign push    = accept && (!full || pop);
    assign gap_inc = (g == GAP_MAX) ? g : g + 1'b1;

    assign gap_valid = !empty;
    assign gap_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            level     <= 1'b0;
            data_out  <= 1'b0;
            evt_count <= '0;
            g         <= '0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            s1       <= data;
            s2       <= s1;
            data_out <= accept;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (accept) begin
                level     <= s2;
                evt_count <= evt_count + 1'b1;
                g         <= '0;
                if (!push) overflow <= 1'b1;
            end else begin
                g <= gap_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr[AW-1:0]] <= gap_inc;
    end
endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: directed scenarios plus randomized traffic against a
// sliding-window reference model. Honours TOGGLE_DEC_FILTER_EN the same way as the design.
module tb_toggle_event_decoder;
    localparam int FC = 2, CNT_W = 8, GAP_W = 8, DEPTH = 4;
`ifdef TOGGLE_DEC_FILTER_EN
    localparam int WIN = FC;
`else
    localparam int WIN = 1;
`endif
    localparam int LAT = WIN + 1;
    localparam int GAP_MAX = (1 << GAP_W) - 1;

    logic clk = 1'b0, reset = 1'b0, data = 1'b0, gap_ready = 1'b0;
    logic data_out, level, gap_valid, overflow;
    logic [CNT_W-1:0] evt_count;
    logic [GAP_W-1:0] gap_data;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    toggle_event_decoder #(.FILTER_CYCLES(FC), .CNT_W(CNT_W), .GAP_W(GAP_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data(data), .data_out(data_out), .level(level),
        .evt_count(evt_count), .gap_valid(gap_valid), .gap_data(gap_data),
        .gap_ready(gap_ready), .overflow(overflow)
    );

    // Reference model: an event is accepted once the last WIN synchronised samples all
    // differ from the accepted level; gaps are edge distances between accepted events.
    int               cyc = 0, rst_last = 0, m_g = 0;
    logic             m_pipe0 = 1'b0, m_pipe1 = 1'b0;
    logic             m_win[$];
    logic             m_level = 1'b0, m_pulse = 1'b0, m_ovf = 1'b0;
    logic [CNT_W-1:0] m_count = '0;
    logic [GAP_W-1:0] exp_q[$];

    always @(posedge clk) begin
        logic acc;
        int   ng;
        cyc++;
        if (!reset) begin
            rst_last = cyc;
            m_pipe0 = 1'b0; m_pipe1 = 1'b0;
            m_win.delete();
            for (int i = 0; i < WIN; i++) m_win.push_back(1'b0);
            m_level = 1'b0; m_pulse = 1'b0; m_ovf = 1'b0; m_count = '0; m_g = 0;
            exp_q.delete();
        end else begin
            m_win.push_back(m_pipe1);
            void'(m_win.pop_front());
            acc = 1'b1;
            foreach (m_win[i]) if (m_win[i] == m_level) acc = 1'b0;
            if (exp_q.size() > 0 && gap_ready) void'(exp_q.pop_front());
            ng = (m_g >= GAP_MAX) ? GAP_MAX : m_g + 1;
            if (acc) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(GAP_W'(ng));
                else m_ovf = 1'b1;
                m_g = 0;
                m_level = !m_level;
                m_count = m_count + 1'b1;
            end else begin
                m_g = ng;
            end
            m_pulse = acc;
            m_pipe1 = m_pipe0;
            m_pipe0 = data;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input logic d_at_release);
        reset = 1'b0;
        data  = 1'b0;
        step(2);
        data  = d_at_release;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; data = 1'b0; gap_ready = 1'b0;
        step(3);
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out got %b exp 0", data_out); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset_level got %b exp 0", level); end
        checks++; if (evt_count !== '0) begin errors++; $display("FAIL reset_evt_count got %0d exp 0", evt_count); end
        checks++; if (gap_valid !== 1'b0) begin errors++; $display("FAIL reset_gap_valid got %b exp 0", gap_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        reset = 1'b1;
        step(6);
        checks++; if (evt_count !== '0) begin errors++; $display("FAIL reset_release_quiet got %0d exp 0", evt_count); end
    endtask

    task automatic test_two_toggles;
        int t_first, p1 = -1, p2 = -1, hi = 0;
        data = 1'b1;
        t_first = cyc + 1;
        for (int i = 1; i <= 25; i++) begin
            step(1);
            if (data_out === 1'b1) begin
                hi++;
                if (p1 < 0) p1 = cyc; else if (p2 < 0) p2 = cyc;
            end
            if (i == 10) data = 1'b0;
        end
        checks++; if (p1 - t_first != LAT) begin errors++; $display("FAIL two_latency got %0d exp %0d", p1 - t_first, LAT); end
        checks++; if (p2 - p1 != 10) begin errors++; $display("FAIL two_spacing got %0d exp 10", p2 - p1); end
        checks++; if (hi != 2) begin errors++; $display("FAIL two_pulse_cycles got %0d exp 2", hi); end
        checks++; if (evt_count !== 8'd2) begin errors++; $display("FAIL two_evt_count got %0d exp 2", evt_count); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL two_level got %b exp 0", level); end
        checks++; if (gap_valid !== 1'b1 || gap_data !== GAP_W'(t_first + LAT - rst_last))
            begin errors++; $display("FAIL two_first_gap got v%b %0d exp v1 %0d", gap_valid, gap_data, t_first + LAT - rst_last); end
        gap_ready = 1'b1;
        step(1);
        checks++; if (gap_valid !== 1'b1 || gap_data !== 8'd10) begin errors++; $display("FAIL two_second_gap got v%b %0d exp v1 10", gap_valid, gap_data); end
        step(1);
        gap_ready = 1'b0;
        checks++; if (gap_valid !== 1'b0) begin errors++; $display("FAIL two_drained got %b exp 0", gap_valid); end
    endtask

    task automatic test_glitch;
        int hi = 0, exp_ev;
        exp_ev = (WIN > 1) ? 0 : 2;
        apply_reset(1'b0);
        step(4);
        data = 1'b1;
        step(1);
        data = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (data_out === 1'b1) hi++;
        end
        checks++; if (hi != exp_ev) begin errors++; $display("FAIL glitch_pulses got %0d exp %0d", hi, exp_ev); end
        checks++; if (evt_count !== CNT_W'(exp_ev)) begin errors++; $display("FAIL glitch_evt_count got %0d exp %0d", evt_count, exp_ev); end
        checks++; if (level !== 1'b0) begin errors++; $display("FAIL glitch_level got %b exp 0", level); end
    endtask

    task automatic test_overflow;
        int t1 = 0;
        apply_reset(1'b0);
        gap_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            data = ~data;
            if (k == 1) t1 = cyc + 1;
            step(5);
            checks++; if (overflow !== (k >= 5)) begin errors++; $display("FAIL ovf_after_event%0d got %b exp %b", k, overflow, k >= 5); end
        end
        checks++; if (evt_count !== 8'd6) begin errors++; $display("FAIL ovf_evt_count got %0d exp 6", evt_count); end
        gap_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            int exp_g;
            exp_g = (j == 0) ? (t1 + LAT - rst_last) : 5;
            checks++; if (gap_valid !== 1'b1 || gap_data !== GAP_W'(exp_g))
                begin errors++; $display("FAIL ovf_drain%0d got v%b %0d exp v1 %0d", j, gap_valid, gap_data, exp_g); end
            step(1);
        end
        gap_ready = 1'b0;
        checks++; if (gap_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", gap_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_full_push_pop;
        int n = 0;
        apply_reset(1'b0);
        gap_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data = ~data;
            step(5);
        end
        data = ~data;
        step(LAT);
        gap_ready = 1'b1;
        step(1);
        gap_ready = 1'b0;
        checks++; if (data_out !== 1'b1) begin errors++; $display("FAIL fpp_pulse got %b exp 1", data_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %b exp 0", overflow); end
        gap_ready = 1'b1;
        while (gap_valid === 1'b1 && n < 10) begin
            checks++; if (gap_data !== 8'd5) begin errors++; $display("FAIL fpp_entry%0d got %0d exp 5", n, gap_data); end
            n++;
            step(1);
        end
        gap_ready = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL fpp_entries got %0d exp 4", n); end
    endtask

    task automatic test_saturation;
        apply_reset(1'b0);
        step(300);
        data = 1'b1;
        step(LAT + 1);
        checks++; if (gap_valid !== 1'b1 || gap_data !== 8'd255) begin errors++; $display("FAIL sat_gap got v%b %0d exp v1 255", gap_valid, gap_data); end
        checks++; if (evt_count !== 8'd1) begin errors++; $display("FAIL sat_evt_count got %0d exp 1", evt_count); end
    endtask

    task automatic test_mid_reset;
        int hi = 0;
        apply_reset(1'b0);
        gap_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data = ~data;
            step(5);
        end
        checks++; if (evt_count !== 8'd3) begin errors++; $display("FAIL mid_pre_count got %0d exp 3", evt_count); end
        data = ~data;
        step(LAT);
        reset = 1'b0;
        step(1);
        checks++; if (data_out !== 1'b0 || level !== 1'b0 || evt_count !== '0 || gap_valid !== 1'b0 || overflow !== 1'b0)
            begin errors++; $display("FAIL mid_reset_outputs got %b%b %0d %b%b exp 00 0 00", data_out, level, evt_count, gap_valid, overflow); end
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin step(1); if (data_out === 1'b1) hi++; end
        checks++; if (hi != 0 || evt_count !== '0) begin errors++; $display("FAIL mid_release_low got pulses %0d count %0d exp 0 0", hi, evt_count); end
        hi = 0;
        apply_reset(1'b1);
        for (int i = 0; i < 20; i++) begin step(1); if (data_out === 1'b1) hi++; end
        checks++; if (hi != 1 || evt_count !== 8'd1 || level !== 1'b1)
            begin errors++; $display("FAIL mid_release_high got pulses %0d count %0d level %b exp 1 1 1", hi, evt_count, level); end
    endtask

    task automatic test_random;
        int hold = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                data = ~data;
                hold = $urandom_range(1, 8);
            end
            hold--;
            gap_ready = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 499) != 0);
            step(1);
            checks++; if (data_out !== m_pulse) begin errors++; $display("FAIL rnd_data_out cyc %0d got %b exp %b", cyc, data_out, m_pulse); end
            checks++; if (level !== m_level) begin errors++; $display("FAIL rnd_level cyc %0d got %b exp %b", cyc, level, m_level); end
            checks++; if (evt_count !== m_count) begin errors++; $display("FAIL rnd_evt_count cyc %0d got %0d exp %0d", cyc, evt_count, m_count); end
            checks++; if (gap_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_gap_valid cyc %0d got %b exp %b", cyc, gap_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if (gap_data !== exp_q[0]) begin errors++; $display("FAIL rnd_gap_data cyc %0d got %0d exp %0d", cyc, gap_data, exp_q[0]); end
            end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d got %b exp %b", cyc, overflow, m_ovf); end
        end
        reset = 1'b1;
        gap_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_toggles();
        test_glitch();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
